// File: rtl/electron_clk_gen.sv
// Electron phi0 generator: stretches each CPU cycle by address region (ROM fast, IO slot-aligned, RAM slot-aligned and contended).
// Optional macro TURBO_RAM_EN lets the turbo card run 0x0000-0x2FFF at full speed when turbo_ram is high.
module electron_clk_gen #(
    parameter int LOW_TICKS  = 4,
    parameter int HIGH_TICKS = 4,
    parameter int SLOT_LEN   = 16,
    parameter int SLOT_GRANT = 11
) (
    input  logic       master_clk_in,
    input  logic       reset,
    input  logic [7:0] cpu_address,
    input  logic       cpu_rw,
    input  logic       ram_contend,
    input  logic       turbo_ram,
    output logic       cpu_clk_out,
    output logic [1:0] cycle_type,
    output logic       ram_grant,
    output logic       cycle_done
);

    localparam int SW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int CW = 8;

    localparam logic [1:0] ST_LOW  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    localparam logic [1:0] CT_FAST = 2'b00;
    localparam logic [1:0] CT_IO   = 2'b01;
    localparam logic [1:0] CT_RAM  = 2'b10;

    localparam logic [CW-1:0] LOW_LAST   = CW'(LOW_TICKS - 1);
    localparam logic [CW-1:0] HIGH_LAST  = CW'(HIGH_TICKS - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_LEN - 1);
    localparam logic [SW-1:0] SLOT_GRANT_V = SW'(SLOT_GRANT);

    function automatic logic [1:0] decode_region(input logic [7:0] addr);
        logic [1:0] region;
        if (addr <= 8'h7F) begin
            region = CT_RAM;
        end else if ((addr >= 8'hFC) && (addr <= 8'hFE)) begin
            region = CT_IO;
        end else begin
            region = CT_FAST;
        end
        return region;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] low_cnt_q, low_cnt_d;
    logic [CW-1:0] high_cnt_q, high_cnt_d;
    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    cycle_type_q, cycle_type_d;
    logic          cpu_clk_out_q, cpu_clk_out_d;
    logic          ram_grant_q, ram_grant_d;
    logic          cycle_done_q, cycle_done_d;
    logic [1:0]    region_s;
    logic          at_grant_s;
    logic          unused_inputs_s;

    // cpu_rw is only observed by the bench; turbo_ram matters only in the turbo build
    assign unused_inputs_s = cpu_rw ^ turbo_ram;

    // Region of the current address, with the turbo override when enabled
    always_comb begin
`ifdef TURBO_RAM_EN
        if (turbo_ram && (cpu_address <= 8'h2F)) begin
            region_s = CT_FAST;
        end else begin
            region_s = decode_region(cpu_address);
        end
`else
        region_s = decode_region(cpu_address);
`endif
    end

    // Next-state logic for the phi0 sequencer and the free-running slot counter
    always_comb begin
        state_d      = state_q;
        low_cnt_d    = low_cnt_q;
        high_cnt_d   = high_cnt_q;
        cycle_type_d = cycle_type_q;
        at_grant_s   = (slot_cnt_q == SLOT_GRANT_V);
        if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = {SW{1'b0}};
        end else begin
            slot_cnt_d = slot_cnt_q + SW'(1);
        end

        case (state_q)
            ST_LOW: begin
                if (low_cnt_q == LOW_LAST) begin
                    low_cnt_d    = {CW{1'b0}};
                    cycle_type_d = region_s;
                    if (region_s == CT_FAST) begin
                        state_d = ST_HIGH;
                    end else if (at_grant_s && ((region_s == CT_IO) || !ram_contend)) begin
                        state_d = ST_HIGH;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    low_cnt_d = low_cnt_q + CW'(1);
                end
            end
            ST_WAIT: begin
                // A contended RAM grant point simply falls through to the next slot
                if (at_grant_s && ((cycle_type_q == CT_IO) || !ram_contend)) begin
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HIGH: begin
                if (high_cnt_q == HIGH_LAST) begin
                    high_cnt_d = {CW{1'b0}};
                    state_d    = ST_LOW;
                end else begin
                    high_cnt_d = high_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = ST_LOW;
                low_cnt_d  = {CW{1'b0}};
                high_cnt_d = {CW{1'b0}};
            end
        endcase

        cpu_clk_out_d = (state_d == ST_HIGH);
        ram_grant_d   = (state_d == ST_HIGH) && (cycle_type_d == CT_RAM);
        cycle_done_d  = (state_q == ST_HIGH) && (state_d == ST_LOW);
    end

    // State, counters and registered outputs
    always_ff @(posedge master_clk_in) begin
        if (reset) begin
            state_q       <= ST_LOW;
            low_cnt_q     <= {CW{1'b0}};
            high_cnt_q    <= {CW{1'b0}};
            slot_cnt_q    <= {SW{1'b0}};
            cycle_type_q  <= CT_FAST;
            cpu_clk_out_q <= 1'b0;
            ram_grant_q   <= 1'b0;
            cycle_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            low_cnt_q     <= low_cnt_d;
            high_cnt_q    <= high_cnt_d;
            slot_cnt_q    <= slot_cnt_d;
            cycle_type_q  <= cycle_type_d;
            cpu_clk_out_q <= cpu_clk_out_d;
            ram_grant_q   <= ram_grant_d;
            cycle_done_q  <= cycle_done_d;
        end
    end

    assign cpu_clk_out = cpu_clk_out_q;
    assign cycle_type  = cycle_type_q;
    assign ram_grant   = ram_grant_q;
    assign cycle_done  = cycle_done_q;

endmodule

// File: tb/tb_electron_clk_gen.sv
// Bench for electron_clk_gen: per-segment stimulus tables checked period by period against a cycle-interval model.
module tb_electron_clk_gen;

    localparam int MAXL = 512;
`ifdef TURBO_RAM_EN
    localparam bit TURBO_ON = 1'b1;
`else
    localparam bit TURBO_ON = 1'b0;
`endif

    logic       master_clk_in = 1'b0;
    logic       reset;
    logic [7:0] cpu_address;
    logic       cpu_rw;
    logic       ram_contend;
    logic       turbo_ram;
    logic       cpu_clk_out;
    logic [1:0] cycle_type;
    logic       ram_grant;
    logic       cycle_done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] st_addr  [MAXL];
    logic       st_cont  [MAXL];
    logic       st_turbo [MAXL];
    logic       exp_clk  [MAXL];
    logic       exp_grant[MAXL];
    logic       exp_done [MAXL];
    logic [1:0] exp_type [MAXL];

    always #5 master_clk_in = ~master_clk_in;

    electron_clk_gen dut (
        .master_clk_in (master_clk_in),
        .reset         (reset),
        .cpu_address   (cpu_address),
        .cpu_rw        (cpu_rw),
        .ram_contend   (ram_contend),
        .turbo_ram     (turbo_ram),
        .cpu_clk_out   (cpu_clk_out),
        .cycle_type    (cycle_type),
        .ram_grant     (ram_grant),
        .cycle_done    (cycle_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // 0 = FAST, 1 = IO, 2 = RAM
    function automatic logic [1:0] ref_region(input logic [7:0] a, input logic turbo_active);
        if (turbo_active && (a <= 8'h2F)) return 2'b00;
        if (a < 8'h80) return 2'b10;
        if ((a >= 8'hFC) && (a != 8'hFF)) return 2'b01;
        return 2'b00;
    endfunction

    // Period t follows the t-th edge after reset; slot number is t mod 16.
    // A cycle starting at period s decodes on the edge ending period s+3, then the high phase
    // follows the first eligible grant edge g (g = decode edge for FAST).
    task automatic build_model(input int len);
        int s;
        int d;
        int g;
        logic [1:0] k;
        for (int p = 0; p < len; p++) begin
            exp_clk[p]   = 1'b0;
            exp_grant[p] = 1'b0;
            exp_done[p]  = 1'b0;
            exp_type[p]  = 2'b00;
        end
        s = 0;
        while (1) begin
            d = s + 3;
            if (d >= len) break;
            k = ref_region(st_addr[d], TURBO_ON && st_turbo[d]);
            for (int p = d + 1; p < len; p++) exp_type[p] = k;
            g = d;
            if (k != 2'b00) begin
                while ((g < len) && !(((g % 16) == 11) && ((k == 2'b01) || !st_cont[g]))) g++;
            end
            if (g >= len) break;
            for (int p = g + 1; (p <= g + 4) && (p < len); p++) begin
                exp_clk[p]   = 1'b1;
                exp_grant[p] = (k == 2'b10);
            end
            if (g + 5 < len) exp_done[g + 5] = 1'b1;
            s = g + 5;
        end
    endtask

    task automatic gen_stim(input int scn, input int len);
        logic c;
        int   r;
        c = 1'b0;
        for (int t = 0; t < len; t++) begin
            st_turbo[t] = 1'b0;
            st_cont[t]  = 1'b0;
            case (scn)
                0, 4, 5: st_addr[t] = 8'hC0;
                1:       st_addr[t] = 8'hFE;
                2:       st_addr[t] = 8'h40;
                3: begin
                    st_addr[t] = 8'h40;
                    st_cont[t] = (t < 48);
                end
                6: begin
                    st_addr[t]  = 8'h20;
                    st_turbo[t] = 1'b1;
                    st_cont[t]  = 1'b1;
                end
                default: begin
                    r = $urandom_range(0, 5);
                    case (r)
                        0: st_addr[t] = 8'($urandom_range(0, 127));
                        1: st_addr[t] = 8'($urandom_range(252, 254));
                        2: st_addr[t] = 8'($urandom_range(128, 251));
                        3: st_addr[t] = 8'hFF;
                        4: st_addr[t] = 8'($urandom_range(0, 47));
                        default: st_addr[t] = 8'($urandom_range(0, 255));
                    endcase
                    if ($urandom_range(0, 7) == 0) c = ~c;
                    st_cont[t]  = c;
                    st_turbo[t] = 1'($urandom_range(0, 1));
                end
            endcase
        end
    endtask

    task automatic run_segment(input int seg, input int scn, input int len);
        gen_stim(scn, len);
        build_model(len);
        reset = 1'b1;
        @(posedge master_clk_in);
        #1;
        reset = 1'b0;
        for (int t = 0; t < len; t++) begin
            check_eq($sformatf("s%0d t%0d clk", seg, t),   cpu_clk_out, exp_clk[t]);
            check_eq($sformatf("s%0d t%0d type", seg, t),  cycle_type,  exp_type[t]);
            check_eq($sformatf("s%0d t%0d grant", seg, t), ram_grant,   exp_grant[t]);
            check_eq($sformatf("s%0d t%0d done", seg, t),  cycle_done,  exp_done[t]);
            cpu_address = st_addr[t];
            ram_contend = st_cont[t];
            turbo_ram   = st_turbo[t];
            cpu_rw      = 1'($urandom_range(0, 1));
            @(posedge master_clk_in);
            #1;
        end
    endtask

    initial begin
        int seg_len [7] = '{40, 64, 64, 80, 5, 24, 48};
        reset       = 1'b1;
        cpu_address = 8'h00;
        cpu_rw      = 1'b1;
        ram_contend = 1'b0;
        turbo_ram   = 1'b0;
        repeat (3) @(posedge master_clk_in);
        #1;
        // Segment 4 ends with reset asserted during the second high clock of a FAST cycle
        for (int i = 0; i < 7; i++) run_segment(i, i, seg_len[i]);
        for (int i = 7; i < 15; i++) run_segment(i, 99, $urandom_range(60, 300));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
